// File: rtl/jtag_mem_bridge.sv
// ============================================================================
// jtag_mem_bridge : runs JTAG-latched commands as handshaked memory accesses
// Revision 1.0
// ============================================================================
`default_nettype none

module jtag_mem_bridge #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 255,
  parameter int INC_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_upd,
  input  logic [7:0]        jtag_instr,
  input  logic [DATA_W-1:0] jtag_din,
  output logic [DATA_W-1:0] jtag_dout,
  output logic              jtag_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_acc  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [7:0] c_cmd_set_addr  = 8'h01;
  localparam logic [7:0] c_cmd_read      = 8'h02;
  localparam logic [7:0] c_cmd_write     = 8'h03;
  localparam logic [7:0] c_cmd_read_inc  = 8'h04;
  localparam logic [7:0] c_cmd_write_inc = 8'h05;
  localparam logic [7:0] c_cmd_status    = 8'h06;
  localparam logic [7:0] c_cmd_clr_err   = 8'h07;

  // Wait counter only has to reach TIMEOUT-1: abort fires on the TIMEOUT-th cycle.
  localparam int                 c_cnt_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit                 c_to_en   = (TIMEOUT != 0);
  localparam logic [c_cnt_w-1:0] c_to_last = (TIMEOUT == 0) ? '0 : c_cnt_w'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]  c_inc     = ADDR_W'(INC_STEP);

  logic                r_upd_q;
  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_addr_reg;
  logic                r_inc;
  logic [c_cnt_w-1:0]  r_wait;
  logic                r_to_err;
  logic                r_ovr_err;
  logic                w_edge;
  logic [DATA_W-1:0]   w_status;

  assign w_edge = jtag_upd & ~r_upd_q;
  assign err    = r_to_err | r_ovr_err;

  always_comb begin
    w_status      = '0;
    w_status[2:0] = {r_to_err, r_ovr_err, busy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_q    <= 1'b0;
      r_state    <= c_st_idle;
      r_addr_reg <= '0;
      r_inc      <= 1'b0;
      r_wait     <= '0;
      r_to_err   <= 1'b0;
      r_ovr_err  <= 1'b0;
      jtag_dout  <= '0;
      jtag_wr    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_upd_q <= jtag_upd;
      jtag_wr <= 1'b0;

      case (r_state)
        c_st_idle: begin
          if (w_edge) begin
            case (jtag_instr)
              c_cmd_set_addr: r_addr_reg <= jtag_din[ADDR_W-1:0];
              c_cmd_read, c_cmd_write, c_cmd_read_inc, c_cmd_write_inc: begin
                r_state   <= c_st_acc;
                mem_en    <= 1'b1;
                mem_wr    <= jtag_instr[0];
                mem_addr  <= r_addr_reg;
                mem_wdata <= jtag_din;
                busy      <= 1'b1;
                r_inc     <= (jtag_instr == c_cmd_read_inc) || (jtag_instr == c_cmd_write_inc);
                r_wait    <= '0;
              end
              c_cmd_status: begin
                jtag_dout <= w_status;
                jtag_wr   <= 1'b1;
              end
              c_cmd_clr_err: begin
                r_to_err  <= 1'b0;
                r_ovr_err <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        c_st_acc: begin
          // Completion takes priority over a timeout expiring in the same cycle.
          if (mem_rdy) begin
            mem_en  <= 1'b0;
            r_state <= c_st_done;
            if (!mem_wr) begin
              jtag_dout <= mem_rdata;
              jtag_wr   <= 1'b1;
            end
            if (r_inc) r_addr_reg <= r_addr_reg + c_inc;
          end else if (c_to_en && (r_wait == c_to_last)) begin
            mem_en   <= 1'b0;
            r_state  <= c_st_done;
            r_to_err <= 1'b1;
            if (!mem_wr) begin
              jtag_dout <= '1;
              jtag_wr   <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + c_cnt_w'(1);
          end
        end

        c_st_done: begin
          r_state <= c_st_idle;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= c_st_idle;
          mem_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      if (w_edge && (r_state != c_st_idle)) r_ovr_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_mem_bridge.sv
// ============================================================================
// tb_jtag_mem_bridge : directed self-checking bench for jtag_mem_bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_jtag_mem_bridge;

  localparam logic [7:0] c_set_addr  = 8'h01;
  localparam logic [7:0] c_read      = 8'h02;
  localparam logic [7:0] c_write     = 8'h03;
  localparam logic [7:0] c_write_inc = 8'h05;
  localparam logic [7:0] c_status    = 8'h06;
  localparam logic [7:0] c_clr_err   = 8'h07;

  logic        clk = 1'b0;
  logic        rst;
  logic        jtag_upd;
  logic [7:0]  jtag_instr;
  logic [15:0] jtag_din;
  logic [15:0] jtag_dout;
  logic        jtag_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic        mem_rdy;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  jtag_mem_bridge #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT(4), .INC_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .jtag_upd(jtag_upd), .jtag_instr(jtag_instr),
    .jtag_din(jtag_din), .jtag_dout(jtag_dout), .jtag_wr(jtag_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_rdy(mem_rdy), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; presents the command in cycle N, returns at negedge of N+1.
  task automatic issue(input logic [7:0] instr, input logic [15:0] din);
    jtag_instr = instr;
    jtag_din   = din;
    jtag_upd   = 1'b1;
    tick(1);
    jtag_upd   = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({mem_en, mem_wr, jtag_wr, busy, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 00000", {mem_en, mem_wr, jtag_wr, busy, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, jtag_dout} !== 48'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {mem_addr, mem_wdata, jtag_dout});
    end
  endtask

  task automatic test_single_read;
    issue(c_set_addr, 16'h0040);
    tick(1);
    issue(c_read, 16'h0000);
    checks++;
    if ({mem_en, mem_wr, busy, mem_addr} !== {3'b101, 16'h0040}) begin
      errors++; $display("FAIL rd_req: got %h exp %h", {mem_en, mem_wr, busy, mem_addr}, {3'b101, 16'h0040});
    end
    mem_rdy = 1'b1; mem_rdata = 16'hBEEF;
    tick(1);
    mem_rdy = 1'b0;
    checks++;
    if ({jtag_wr, mem_en, busy, jtag_dout} !== {3'b101, 16'hBEEF}) begin
      errors++; $display("FAIL rd_data: got %h exp %h", {jtag_wr, mem_en, busy, jtag_dout}, {3'b101, 16'hBEEF});
    end
    tick(1);
    checks++;
    if ({jtag_wr, busy} !== 2'b00) begin
      errors++; $display("FAIL rd_idle: got %b exp 00", {jtag_wr, busy});
    end
    issue(c_read, 16'h0000);
    checks++;
    if (mem_addr !== 16'h0040) begin
      errors++; $display("FAIL rd_addr_kept: got %h exp 0040", mem_addr);
    end
    mem_rdy = 1'b1; mem_rdata = 16'h1111;
    tick(1);
    mem_rdy = 1'b0;
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h1111}) begin
      errors++; $display("FAIL rd2_data: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h1111});
    end
    tick(1);
  endtask

  task automatic test_burst_write;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    issue(c_set_addr, 16'hFFFF);
    tick(1);
    for (int k = 0; k < 2; k++) begin
      exp_addr = (k == 0) ? 16'hFFFF : 16'h0000;
      exp_data = (k == 0) ? 16'h1234 : 16'h5678;
      issue(c_write_inc, exp_data);
      jtag_din = 16'h0000;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({mem_en, mem_wr, busy, mem_addr, mem_wdata} !== {3'b111, exp_addr, exp_data}) begin
          errors++; $display("FAIL wr_hold k=%0d c=%0d: got %h exp %h", k, c,
                             {mem_en, mem_wr, busy, mem_addr, mem_wdata}, {3'b111, exp_addr, exp_data});
        end
        if (c == 3) mem_rdy = 1'b1;
        tick(1);
      end
      mem_rdy = 1'b0;
      checks++;
      if ({mem_en, jtag_wr, err} !== 3'b000) begin
        errors++; $display("FAIL wr_done k=%0d: got %b exp 000", k, {mem_en, jtag_wr, err});
      end
      tick(1);
    end
    issue(c_read, 16'h0000);
    checks++;
    if (mem_addr !== 16'h0001) begin
      errors++; $display("FAIL wr_wrap_addr: got %h exp 0001", mem_addr);
    end
    mem_rdy = 1'b1; mem_rdata = 16'h0000;
    tick(1);
    mem_rdy = 1'b0;
    tick(1);
  endtask

  task automatic test_timeout;
    issue(c_read, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem_en !== 1'b1) begin
        errors++; $display("FAIL to_en c=%0d: got %b exp 1", c, mem_en);
      end
      tick(1);
    end
    checks++;
    if ({mem_en, jtag_wr, err, jtag_dout} !== {3'b011, 16'hFFFF}) begin
      errors++; $display("FAIL to_abort: got %h exp %h", {mem_en, jtag_wr, err, jtag_dout}, {3'b011, 16'hFFFF});
    end
    tick(1);
    issue(c_status, 16'h0000);
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h0004}) begin
      errors++; $display("FAIL to_status: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h0004});
    end
    tick(1);
    checks++;
    if (jtag_wr !== 1'b0) begin
      errors++; $display("FAIL status_pulse: got %b exp 0", jtag_wr);
    end
    issue(c_clr_err, 16'h0000);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL clr_err: got %b exp 0", err);
    end
    tick(1);
    issue(c_status, 16'h0000);
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL clr_status: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h0000});
    end
    tick(1);
  endtask

  task automatic test_overrun;
    issue(c_read, 16'h0000);
    tick(1);
    issue(c_write, 16'hABCD);
    checks++;
    if ({err, mem_en, mem_wr} !== 3'b110) begin
      errors++; $display("FAIL ovr_flag: got %b exp 110", {err, mem_en, mem_wr});
    end
    mem_rdy = 1'b1; mem_rdata = 16'h2222;
    tick(1);
    mem_rdy = 1'b0;
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h2222}) begin
      errors++; $display("FAIL ovr_rd: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h2222});
    end
    tick(1);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({mem_en, busy} !== 2'b00) begin
        errors++; $display("FAIL ovr_no_access c=%0d: got %b exp 00", c, {mem_en, busy});
      end
      tick(1);
    end
    issue(c_status, 16'h0000);
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h0002}) begin
      errors++; $display("FAIL ovr_status: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h0002});
    end
    tick(1);
    issue(c_clr_err, 16'h0000);
    tick(1);
  endtask

  task automatic test_rdy_at_timeout;
    issue(c_read, 16'h0000);
    tick(3);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL tie_en: got %b exp 1", mem_en);
    end
    mem_rdy = 1'b1; mem_rdata = 16'hCAFE;
    tick(1);
    mem_rdy = 1'b0;
    checks++;
    if ({jtag_wr, err, jtag_dout} !== {2'b10, 16'hCAFE}) begin
      errors++; $display("FAIL tie_rd: got %h exp %h", {jtag_wr, err, jtag_dout}, {2'b10, 16'hCAFE});
    end
    tick(1);
  endtask

  task automatic test_unknown;
    issue(8'h7F, 16'h5555);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({mem_en, jtag_wr, busy, err} !== 4'b0000) begin
        errors++; $display("FAIL unknown c=%0d: got %b exp 0000", c, {mem_en, jtag_wr, busy, err});
      end
      tick(1);
    end
  endtask

  task automatic test_reset_mid_access;
    issue(c_read, 16'h0000);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_pre_en: got %b exp 1", mem_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_wr, jtag_wr, busy, err, mem_addr, mem_wdata, jtag_dout} !== 53'h0) begin
      errors++; $display("FAIL rst_async: got %h exp 0",
                         {mem_en, mem_wr, jtag_wr, busy, err, mem_addr, mem_wdata, jtag_dout});
    end
    tick(1);
    rst = 1'b0;
    issue(c_read, 16'h0000);
    checks++;
    if ({mem_en, busy, mem_addr} !== {2'b11, 16'h0000}) begin
      errors++; $display("FAIL rst_rd_req: got %h exp %h", {mem_en, busy, mem_addr}, {2'b11, 16'h0000});
    end
    mem_rdy = 1'b1; mem_rdata = 16'h7777;
    tick(1);
    mem_rdy = 1'b0;
    checks++;
    if ({jtag_wr, jtag_dout} !== {1'b1, 16'h7777}) begin
      errors++; $display("FAIL rst_rd_data: got %h exp %h", {jtag_wr, jtag_dout}, {1'b1, 16'h7777});
    end
    tick(1);
  endtask

  initial begin
    rst        = 1'b1;
    jtag_upd   = 1'b0;
    jtag_instr = 8'h00;
    jtag_din   = 16'h0000;
    mem_rdata  = 16'h0000;
    mem_rdy    = 1'b0;
    tick(2);
    test_reset;
    rst = 1'b0;
    tick(1);
    test_single_read;
    test_burst_write;
    test_timeout;
    test_overrun;
    test_rdy_at_timeout;
    test_unknown;
    test_reset_mid_access;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
